tug_of_war_ctrl: RTL and testbench

Game controller for the two-player tug-of-war playfield. It receives one-cycle press pulses from the per-player button conditioners and arbitrates between them each cycle. It moves a one-hot light across the LED row, detects round wins, and keeps per-player scores up to a match limit. It sits between the two button blocks and the LED/HEX display drivers.

---
 rtl/tug_of_war_ctrl.sv | 127 ++++++++++++
 tb/tb_tug_of_war_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/tug_of_war_ctrl.sv
// Two-player tug-of-war game controller: arbitrates press pulses, moves a one-hot
// light across the playfield, detects round wins and keeps scores up to a match limit.
module tug_of_war_ctrl #(
    parameter int N_POS       = 9,
    parameter int WIN_SCORE   = 7,
    parameter int HOLD_CYCLES = 50
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             press_l,
    input  logic                             press_r,
    output logic [N_POS-1:0]                 led,
    output logic                             winner_l,
    output logic                             winner_r,
    output logic [$clog2(WIN_SCORE+1)-1:0]   score_l,
    output logic [$clog2(WIN_SCORE+1)-1:0]   score_r,
    output logic                             match_over
);

    // state  | meaning
    // PLAY   | light moves with arbitrated presses
    // HOLD_L | left won the round; indication held, presses ignored
    // HOLD_R | right won the round; indication held, presses ignored
    // OVER   | match decided; frozen until reset

    localparam int PW = (N_POS > 1) ? $clog2(N_POS) : 1;
    localparam int SW = $clog2(WIN_SCORE + 1);
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [PW-1:0] CENTER    = PW'((N_POS - 1) / 2);
    localparam logic [PW-1:0] POS_LEFT  = PW'(N_POS - 1);
    localparam logic [SW-1:0] SCORE_MAX = SW'(WIN_SCORE);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        PLAY   = 2'd0,
        HOLD_L = 2'd1,
        HOLD_R = 2'd2,
        OVER   = 2'd3
    } state_t;

    state_t          state, state_next;
    logic [PW-1:0]   pos, pos_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic [SW-1:0]   score_l_next, score_r_next;
    logic            move_l, move_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= PLAY;
            pos     <= CENTER;
            cnt     <= '0;
            score_l <= '0;
            score_r <= '0;
        end else begin
            state   <= state_next;
            pos     <= pos_next;
            cnt     <= cnt_next;
            score_l <= score_l_next;
            score_r <= score_r_next;
        end
    end

    assign move_l = press_l & ~press_r;
    assign move_r = press_r & ~press_l;

    always_comb begin
        state_next   = state;
        pos_next     = pos;
        cnt_next     = cnt;
        score_l_next = score_l;
        score_r_next = score_r;
        led          = '0;
        winner_l     = 1'b0;
        winner_r     = 1'b0;
        match_over   = 1'b0;

        case (state)
            PLAY: begin
                led = {{(N_POS-1){1'b0}}, 1'b1} << pos;
                if (move_l) begin
                    if (pos == POS_LEFT) begin
                        state_next = HOLD_L;
                        cnt_next   = HOLD_LOAD;
                        if (score_l != SCORE_MAX) score_l_next = score_l + 1'b1;
                    end else begin
                        pos_next = pos + 1'b1;
                    end
                end else if (move_r) begin
                    if (pos == '0) begin
                        state_next = HOLD_R;
                        cnt_next   = HOLD_LOAD;
                        if (score_r != SCORE_MAX) score_r_next = score_r + 1'b1;
                    end else begin
                        pos_next = pos - 1'b1;
                    end
                end
            end

            HOLD_L, HOLD_R: begin
                winner_l = (state == HOLD_L);
                winner_r = (state == HOLD_R);
                if (cnt == '0) begin
                    if ((state == HOLD_L && score_l == SCORE_MAX) ||
                        (state == HOLD_R && score_r == SCORE_MAX)) begin
                        state_next = OVER;
                    end else begin
                        state_next = PLAY;
                        pos_next   = CENTER;
                    end
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end

            OVER: begin
                // Only the match winner can have reached the limit.
                winner_l   = (score_l == SCORE_MAX);
                winner_r   = (score_r == SCORE_MAX);
                match_over = 1'b1;
            end

            default: state_next = PLAY;
        endcase
    end

endmodule

// File: tb/tb_tug_of_war_ctrl.sv
// Scoreboard bench for tug_of_war_ctrl: a behavioural game model pushes expected
// outputs per cycle; they are popped and compared after each clock edge.
module tb_tug_of_war_ctrl;

    localparam int N = 9;
    localparam int W = 7;
    localparam int H = 50;
    localparam int C = (N - 1) / 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         press_l, press_r;
    logic [N-1:0] led;
    logic         winner_l, winner_r;
    logic [2:0]   score_l, score_r;
    logic         match_over;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [N-1:0] led;
        logic         wl;
        logic         wr;
        logic [2:0]   sl;
        logic [2:0]   sr;
        logic         mo;
    } exp_t;

    exp_t exp_q[$];

    // model state: 0 play, 1 left holding, 2 right holding, 3 match over
    int m_st, m_pos, m_cnt, m_sl, m_sr;

    tug_of_war_ctrl #(.N_POS(N), .WIN_SCORE(W), .HOLD_CYCLES(H)) dut (
        .clk        (clk),
        .reset      (reset),
        .press_l    (press_l),
        .press_r    (press_r),
        .led        (led),
        .winner_l   (winner_l),
        .winner_r   (winner_r),
        .score_l    (score_l),
        .score_r    (score_r),
        .match_over (match_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_edge(input logic r, input logic pl, input logic pr);
        if (r) begin
            m_st = 0; m_pos = C; m_cnt = 0; m_sl = 0; m_sr = 0;
            return;
        end
        case (m_st)
            0: begin
                if (pl && !pr) begin
                    if (m_pos == N - 1) begin m_sl++; m_st = 1; m_cnt = H - 1; end
                    else m_pos++;
                end else if (pr && !pl) begin
                    if (m_pos == 0) begin m_sr++; m_st = 2; m_cnt = H - 1; end
                    else m_pos--;
                end
            end
            1, 2: begin
                if (m_cnt > 0) m_cnt--;
                else if ((m_st == 1 && m_sl == W) || (m_st == 2 && m_sr == W)) m_st = 3;
                else begin m_st = 0; m_pos = C; end
            end
            default: ;
        endcase
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.led = '0;
        if (m_st == 0) e.led[m_pos] = 1'b1;
        e.wl = (m_st == 1) || (m_st == 3 && m_sl == W);
        e.wr = (m_st == 2) || (m_st == 3 && m_sr == W);
        e.sl = 3'(m_sl);
        e.sr = 3'(m_sr);
        e.mo = (m_st == 3);
        return e;
    endfunction

    task automatic step(input logic r, input logic pl, input logic pr);
        exp_t e;
        reset   = r;
        press_l = pl;
        press_r = pr;
        model_edge(r, pl, pr);
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("led", 32'(led), 32'(e.led));
        check("winner_l", 32'(winner_l), 32'(e.wl));
        check("winner_r", 32'(winner_r), 32'(e.wr));
        check("score_l", 32'(score_l), 32'(e.sl));
        check("score_r", 32'(score_r), 32'(e.sr));
        check("match_over", 32'(match_over), 32'(e.mo));
        reset   = 1'b0;
        press_l = 1'b0;
        press_r = 1'b0;
    endtask

    initial begin
        int hold_len;
        reset = 1'b1; press_l = 1'b0; press_r = 1'b0;
        m_st = 0; m_pos = C; m_cnt = 0; m_sl = 0; m_sr = 0;

        step(1, 0, 0);
        step(1, 0, 0);
        check("reset_led", 32'(led), 32'h010);
        step(0, 0, 0);

        // four spaced left presses reach the left end; fifth wins the round
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0);
            step(0, 0, 0);
        end
        check("left_end_led", 32'(led), 32'h100);
        step(0, 1, 0);
        check("win_score_l", 32'(score_l), 32'd1);

        // right hammers during the hold; hold length measured from DUT outputs
        hold_len = 1;
        while (winner_l && hold_len < 200) begin
            step(0, 0, 1);
            if (winner_l) hold_len++;
        end
        check("hold_len", 32'(hold_len), 32'(H));
        check("after_hold_led", 32'(led), 32'h010);

        // drive to pos 0, simultaneous press cancels, lone right press wins
        for (int i = 0; i < 4; i++) step(0, 0, 1);
        check("right_end_led", 32'(led), 32'h001);
        step(0, 1, 1);
        check("cancel_led", 32'(led), 32'h001);
        step(0, 0, 1);
        check("right_win_score", 32'(score_r), 32'd1);
        for (int i = 0; i < H; i++) step(0, 0, 0);

        // left takes the remaining rounds with back-to-back presses from the first PLAY cycle
        while (m_sl < W) begin
            for (int i = 0; i < 5; i++) step(0, 1, 0);
            for (int i = 0; i < H; i++) step(0, 0, 0);
        end
        check("final_match_over", 32'(match_over), 32'd1);
        check("final_score_l", 32'(score_l), 32'(W));
        for (int i = 0; i < 20; i++) step(0, i[0], ~i[1]);

        // reset ten cycles into the third right-win hold
        step(1, 0, 0);
        for (int rnd = 0; rnd < 3; rnd++) begin
            for (int i = 0; i < 5; i++) step(0, 0, 1);
            if (rnd < 2) for (int i = 0; i < H; i++) step(0, 0, 0);
        end
        for (int i = 0; i < 9; i++) step(0, 0, 0);
        check("pre_reset_score_r", 32'(score_r), 32'd3);
        check("pre_reset_winner_r", 32'(winner_r), 32'd1);
        step(1, 0, 0);
        check("mid_hold_reset_led", 32'(led), 32'h010);

        // random play
        for (int i = 0; i < 3000; i++) begin
            logic pl, pr;
            pl = ($urandom_range(0, 2) == 0);
            pr = ($urandom_range(0, 2) == 0);
            step(($urandom_range(0, 999) == 0), pl, pr);
        end

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
